// File: rtl/priority_encoder_drain.sv
// rtl/priority_encoder_drain.sv - handshaked priority encoder that drains every set request bit, one index per beat
// Build option: define PRIO_ENC_HIGH_FIRST_EN to drain from the MSB downward (default drains from bit 0 upward).
module priority_encoder_drain #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_last
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pend;
  logic             zero;
  logic             rst_done;
  logic [IDX_W-1:0] sel_idx;
  logic             at_most_one;
  logic             accept;
  logic             beat_done;

  // Clearing the lowest set bit leaves zero only when at most one bit was pending.
  assign at_most_one = ((pend & (pend - WIDTH'(1))) == '0);

  // Only accept once a full clock has passed with reset released.
  assign accept    = (state == IDLE) && in_valid && rst_done && !rst;
  assign beat_done = (state == DRAIN) && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Delays in_ready by one cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  // Capture a new vector in IDLE, then knock out the serviced bit on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      zero <= 1'b0;
    end else if (accept) begin
      pend <= req;
      zero <= (req == '0);
    end else if (beat_done) begin
      pend <= pend & ~(WIDTH'(1) << sel_idx);
    end
  end

  // Pick the winning pending bit; the loop order makes the last match win.
  always_comb begin
    sel_idx = '0;
`ifdef PRIO_ENC_HIGH_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pend[i]) sel_idx = IDX_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend[i]) sel_idx = IDX_W'(i);
    end
`endif
  end

  // Next-state and output decode; outputs depend only on registered state (plus rst gating in_ready).
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_none  = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_done && !rst;
        if (accept) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_idx   = sel_idx;
        out_none  = zero;
        out_last  = zero || at_most_one;
        if (out_ready && (zero || at_most_one)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
